sdft_tick_scheduler: RTL and testbench

Sequencer placed in front of one `sdft_rl` instance. It accepts time-domain samples on a valid/ready stream, buffers them in a small FIFO, and issues `sample_tick`/data to the SDFT no faster than one per block period. It also runs the multi-block clear sequence that flushes the SDFT comb and resonator memories, on request and after reset. It aggregates the SDFT saturation alarm into a sticky status flag.

---
 rtl/sdft_tick_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_sdft_tick_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdft_tick_scheduler.sv
// -----------------------------------------------------------------------------
// sdft_tick_scheduler
//
// Sequencer that sits in front of one sdft_rl instance. Time-domain samples
// arrive on a valid/ready stream and are held in a small FIFO. The scheduler
// hands them to the SDFT with a one-cycle sample_tick, at most one per block
// period of BLOCK_LEN cycles. It also runs the clear sequence that flushes the
// SDFT comb and resonator memories. That sequence is CLEAR_BLOCKS ticks with
// clear_o=1 and data_o=0, and it runs on request and, optionally, after reset.
// The SDFT saturation alarm is folded into a sticky status flag.
//
// Parameters
//   N              SDFT length (power of 2)
//   DW             sample width
//   SPECTRUM       "full" or "half"; must match the driven SDFT
//   FIFO_DEPTH     input buffer depth (power of 2, >= 2)
//   CLEAR_ON_RESET 1 = a clear sequence runs automatically after reset release
//
// Ports
//   clk_i          clock
//   arst_n_i       asynchronous active-low reset
//   in_data_i      signed input sample
//   in_valid_i     input sample valid
//   in_ready_o     FIFO not full (registered)
//   clear_req_i    single-cycle clear request
//   sat_alarm_i    saturation alarm from the SDFT
//   sample_tick_o  one-cycle tick to the SDFT
//   data_o         sample to the SDFT, stable from one tick to the next
//   clear_o        SDFT clear_i, meaningful at a tick and held until the next
//   busy_o         an SDFT block is in progress
//   clearing_o     clear sequence in progress
//   sat_flag_o     sticky saturation seen since the last clear
//   fifo_level_o   FIFO occupancy
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module sdft_tick_scheduler #(
    parameter int    N              = 4096,
    parameter int    DW             = 16,
    parameter string SPECTRUM       = "full",
    parameter int    FIFO_DEPTH     = 4,
    parameter int    CLEAR_ON_RESET = 1
) (
    input  logic                          clk_i,
    input  logic                          arst_n_i,
    input  logic [DW-1:0]                 in_data_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          clear_req_i,
    input  logic                          sat_alarm_i,
    output logic                          sample_tick_o,
    output logic [DW-1:0]                 data_o,
    output logic                          clear_o,
    output logic                          busy_o,
    output logic                          clearing_o,
    output logic                          sat_flag_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int BLOCK_LEN    = (SPECTRUM == "full") ? N : N / 2;
    localparam int CLEAR_BLOCKS = N / BLOCK_LEN;
    localparam int LW           = $clog2(FIFO_DEPTH) + 1;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int BW           = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    localparam logic [BW-1:0] BLK_LAST = BW'(BLOCK_LEN - 1);
    localparam logic [0:0]    CLR_LAST = 1'(CLEAR_BLOCKS - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CLR_RUN = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t          r_state;
    logic [BW-1:0]   r_blk_cnt;
    logic [0:0]      r_clr_cnt;
    logic            r_clr_pend;

    logic            r_sample_tick;
    logic [DW-1:0]   r_data;
    logic            r_clear;
    logic            r_busy;
    logic            r_clearing;
    logic            r_sat_flag;

    logic [DW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_ready;

    // -------------------------------------------------------------------------
    // Dispatch decision
    //
    // The decision normally made in IDLE is also made in the last cycle of
    // every block. Because of this, back-to-back ticks land exactly BLOCK_LEN
    // cycles apart instead of losing a cycle in IDLE. Priority at a boundary:
    //   1. the next block of a clear sequence already under way,
    //   2. a pending clear request (starts a fresh sequence),
    //   3. a buffered sample.
    // Only the registered level counts as "non-empty", so a word pushed in the
    // same cycle is never popped in that cycle.
    // -------------------------------------------------------------------------
    logic            w_push;
    logic            w_blk_end;
    logic            w_boundary;
    logic            w_clr_more;
    logic            w_enter_clr;
    logic            w_pop;
    logic [LW-1:0]   w_level_next;

    always_comb begin
        w_push      = in_valid_i && r_ready;
        w_blk_end   = (r_state != IDLE) && (r_blk_cnt == BLK_LAST);
        w_boundary  = (r_state == IDLE) || w_blk_end;
        w_clr_more  = (r_state == CLR_RUN) && w_blk_end && (r_clr_cnt != CLR_LAST);
        w_enter_clr = w_boundary && !w_clr_more && r_clr_pend;
        w_pop       = w_boundary && !w_clr_more && !r_clr_pend && (r_level != '0);
    end

    // When a clear sequence starts, the FIFO is flushed. A push in that same
    // cycle still lands, so the level restarts at 0 or 1.
    always_comb begin
        w_level_next = r_level;
        if (w_enter_clr) begin
            w_level_next = LW'(w_push);
        end else begin
            w_level_next = r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage: plain array, written on push, read into data_o at a tick
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // Flushing drops everything between the pointers. A word pushed in
            // this cycle is written at the old write pointer, which becomes
            // the new read pointer, so it survives the flush.
            if (w_enter_clr) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_next;
            r_ready <= (w_level_next < LVL_FULL);
        end
    end

    // -------------------------------------------------------------------------
    // Block sequencer with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state       <= IDLE;
            r_blk_cnt     <= '0;
            r_clr_cnt     <= '0;
            r_clr_pend    <= (CLEAR_ON_RESET != 0);
            r_sample_tick <= 1'b0;
            r_data        <= '0;
            r_clear       <= 1'b0;
            r_busy        <= 1'b0;
            r_clearing    <= 1'b0;
            r_sat_flag    <= 1'b0;
        end else begin
            r_sample_tick <= 1'b0;

            // A request in the cycle the sequence starts must not be lost.
            // So the set wins over the clear-on-entry, and a second full
            // sequence follows.
            if (clear_req_i) begin
                r_clr_pend <= 1'b1;
            end else if (w_enter_clr) begin
                r_clr_pend <= 1'b0;
            end

            // Alarms only count while real data is being transformed. A new
            // clear sequence wipes the flag even if an alarm arrives in the
            // same cycle.
            if (w_enter_clr) begin
                r_sat_flag <= 1'b0;
            end else if (sat_alarm_i && r_busy && !r_clearing) begin
                r_sat_flag <= 1'b1;
            end

            if (w_enter_clr || w_clr_more) begin
                r_state       <= CLR_RUN;
                r_blk_cnt     <= '0;
                r_clr_cnt     <= w_enter_clr ? 1'b0 : r_clr_cnt + 1'b1;
                r_sample_tick <= 1'b1;
                r_data        <= '0;
                r_clear       <= 1'b1;
                r_busy        <= 1'b1;
                r_clearing    <= 1'b1;
            end else if (w_pop) begin
                r_state       <= RUN;
                r_blk_cnt     <= '0;
                r_sample_tick <= 1'b1;
                r_data        <= r_mem[r_rd_ptr];
                r_clear       <= 1'b0;
                r_busy        <= 1'b1;
                r_clearing    <= 1'b0;
            end else if (w_boundary) begin
                // Nothing to issue: rest in IDLE. data_o and clear_o keep the
                // values of the last tick.
                r_state       <= IDLE;
                r_blk_cnt     <= '0;
                r_busy        <= 1'b0;
                r_clearing    <= 1'b0;
            end else begin
                r_blk_cnt     <= r_blk_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready_o    = r_ready;
    assign sample_tick_o = r_sample_tick;
    assign data_o        = r_data;
    assign clear_o       = r_clear;
    assign busy_o        = r_busy;
    assign clearing_o    = r_clearing;
    assign sat_flag_o    = r_sat_flag;
    assign fifo_level_o  = r_level;

endmodule

// File: tb/tb_sdft_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sdft_tick_scheduler
//
// Two instances share clock and reset:
//   u_full : N=16, full spectrum (block 16, one clear block), FIFO depth 4.
//            It gets directed and random stimulus and is compared every cycle
//            against a reference model. The model describes the scheduler in
//            terms of "cycles left in the current block", "clear ticks still
//            owed" and a sample queue.
//   u_half : N=16, half spectrum (block 8, two clear blocks), inputs idle.
//            Its clear sequence after each reset release follows from the
//            cycle count since release.
// -----------------------------------------------------------------------------
module tb_sdft_tick_scheduler;

    localparam int N     = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int BL    = 16;   // full spectrum block length
    localparam int CB    = 1;    // clear blocks, full spectrum
    localparam int BL_H  = 8;    // half spectrum block length

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            arst_n;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            clear_req;
    logic            sat_alarm;

    logic            in_ready;
    logic            sample_tick;
    logic [DW-1:0]   data_o;
    logic            clear_o;
    logic            busy;
    logic            clearing;
    logic            sat_flag;
    logic [2:0]      level;

    logic [DW-1:0]   h_in_data   = '0;
    logic            h_in_valid  = 1'b0;
    logic            h_clear_req = 1'b0;
    logic            h_sat_alarm = 1'b0;
    logic            h_ready;
    logic            h_tick;
    logic [DW-1:0]   h_data;
    logic            h_clear;
    logic            h_busy;
    logic            h_clearing;
    logic            h_sat;
    logic [2:0]      h_level;

    sdft_tick_scheduler #(
        .N(N), .DW(DW), .SPECTRUM("full"), .FIFO_DEPTH(DEPTH), .CLEAR_ON_RESET(1)
    ) u_full (
        .clk_i(clk), .arst_n_i(arst_n),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .clear_req_i(clear_req), .sat_alarm_i(sat_alarm),
        .sample_tick_o(sample_tick), .data_o(data_o), .clear_o(clear_o),
        .busy_o(busy), .clearing_o(clearing), .sat_flag_o(sat_flag),
        .fifo_level_o(level)
    );

    sdft_tick_scheduler #(
        .N(N), .DW(DW), .SPECTRUM("half"), .FIFO_DEPTH(DEPTH), .CLEAR_ON_RESET(1)
    ) u_half (
        .clk_i(clk), .arst_n_i(arst_n),
        .in_data_i(h_in_data), .in_valid_i(h_in_valid), .in_ready_o(h_ready),
        .clear_req_i(h_clear_req), .sat_alarm_i(h_sat_alarm),
        .sample_tick_o(h_tick), .data_o(h_data), .clear_o(h_clear),
        .busy_o(h_busy), .clearing_o(h_clearing), .sat_flag_o(h_sat),
        .fifo_level_o(h_level)
    );

    // ------------------------------------------------------------------ model
    logic [DW-1:0] mq[$];        // samples waiting in the buffer
    bit            m_pend;       // clear requested, not yet started
    bit            m_sat;
    bit            m_in_clear;   // current block belongs to a clear sequence
    bit            m_tick;
    bit            m_clr;
    int            m_left;       // cycles of the current block still to run (0 = idle)
    int            m_clr_left;   // clear ticks still owed after the current one
    logic [DW-1:0] m_data;
    bit            m_accept;

    int checks;
    int errors;
    int cyc;
    int k_h;                     // cycles since reset release
    logic [DW-1:0] nxt;

    task automatic model_reset();
        mq.delete();
        m_pend     = 1'b1;
        m_sat      = 1'b0;
        m_in_clear = 1'b0;
        m_tick     = 1'b0;
        m_clr      = 1'b0;
        m_left     = 0;
        m_clr_left = 0;
        m_data     = '0;
        m_accept   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit push;
        bit busy_now;
        bit clr_now;
        push     = in_valid && (mq.size() < DEPTH);
        busy_now = (m_left > 0);
        clr_now  = m_in_clear && busy_now;
        if (sat_alarm && busy_now && !clr_now) m_sat = 1'b1;
        m_tick = 1'b0;
        if (m_left > 1) begin
            m_left--;
        end else if (m_in_clear && m_clr_left > 0) begin
            m_clr_left--;
            m_left = BL; m_tick = 1'b1; m_data = '0; m_clr = 1'b1;
        end else if (m_pend) begin
            mq.delete();
            m_sat = 1'b0; m_pend = 1'b0; m_in_clear = 1'b1; m_clr_left = CB - 1;
            m_left = BL; m_tick = 1'b1; m_data = '0; m_clr = 1'b1;
        end else if (mq.size() > 0) begin
            m_data = mq.pop_front();
            m_in_clear = 1'b0; m_left = BL; m_tick = 1'b1; m_clr = 1'b0;
        end else begin
            m_left = 0; m_in_clear = 1'b0;
        end
        if (clear_req) m_pend = 1'b1;
        if (push) mq.push_back(in_data);
        m_accept = push;
    endtask

    // --------------------------------------------------------------- checking
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("tick",       sample_tick, m_tick);
        chk("data",       data_o,      m_data);
        chk("clear",      clear_o,     m_clr);
        chk("busy",       busy,        m_left > 0);
        chk("clearing",   clearing,    m_in_clear && (m_left > 0));
        chk("sat",        sat_flag,    m_sat);
        chk("level",      level,       mq.size());
        chk("ready",      in_ready,    mq.size() < DEPTH);
        chk("h_tick",     h_tick,      (k_h == 1) || (k_h == 1 + BL_H));
        chk("h_clear",    h_clear,     k_h >= 1);
        chk("h_clearing", h_clearing,  (k_h >= 1) && (k_h <= 2 * BL_H));
        chk("h_busy",     h_busy,      (k_h >= 1) && (k_h <= 2 * BL_H));
        chk("h_data",     h_data,      0);
        chk("h_ready",    h_ready,     1);
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        cyc++;
        k_h++;
        compare_all();
        if (sample_tick)
            $display("tick cyc=%0d data=%04h clear=%0b level=%0d sat=%0b",
                     cyc, data_o, clear_o, level, sat_flag);
    endtask

    // Step until the model is at block offset blk of a block of the given
    // kind; a timeout counts as a failed comparison.
    task automatic wait_model(input int blk, input bit want_clear, input string tag);
        int n;
        n = 0;
        while (!((m_left == BL - blk) && (m_in_clear == want_clear)) && (n < 300)) begin
            step();
            n++;
        end
        checks++;
        assert (n < 300) else begin
            errors++;
            $error("FAIL %s wait expired after %0d cycles, required fewer than 300", tag, n);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tick"},     sample_tick, 0);
        chk({tag, "_data"},     data_o,      0);
        chk({tag, "_clear"},    clear_o,     0);
        chk({tag, "_busy"},     busy,        0);
        chk({tag, "_clearing"}, clearing,    0);
        chk({tag, "_sat"},      sat_flag,    0);
        chk({tag, "_level"},    level,       0);
        chk({tag, "_ready"},    in_ready,    1);
        chk({tag, "_h_tick"},   h_tick,      0);
        chk({tag, "_h_busy"},   h_busy,      0);
        chk({tag, "_h_ready"},  h_ready,     1);
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        checks = 0; errors = 0; cyc = 0; k_h = 0;
        arst_n = 1'b0; in_valid = 1'b0; in_data = '0; clear_req = 1'b0; sat_alarm = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst_held");

        // Reset release with no input: clear sequence(s), then silence.
        arst_n = 1'b1;
        compare_all();
        repeat (40) step();

        // Continuous stream 1,2,3,...: fills the FIFO, ready drops at level 4.
        nxt = 16'd1;
        for (int i = 0; i < 120; i++) begin
            in_valid = 1'b1; in_data = nxt;
            step();
            if (m_accept) nxt = nxt + 16'd1;
        end
        in_valid = 1'b0;

        // Drain, queue three samples behind a running block, clear at blk_cnt 5.
        for (int i = 0; i < 200 && (m_left > 0 || mq.size() > 0); i++) step();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'h0100 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        wait_model(5, 1'b0, "wait_blk5");
        chk("queued3", level, 3);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (30) step();

        // Saturation: counts in RUN, ignored in CLR_RUN, wiped by a clear.
        in_valid = 1'b1; in_data = 16'h0A5A;
        step();
        in_valid = 1'b0;
        wait_model(3, 1'b0, "wait_run3");
        sat_alarm = 1'b1;
        step();
        sat_alarm = 1'b0;
        chk("sat_set", sat_flag, 1);
        step();
        chk("sat_hold", sat_flag, 1);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        wait_model(4, 1'b1, "wait_clr4");
        sat_alarm = 1'b1;
        step();
        sat_alarm = 1'b0;
        chk("sat_in_clr", sat_flag, 0);
        repeat (20) step();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            clear_req = ($urandom_range(0, 149) == 0);
            sat_alarm = ($urandom_range(0, 7) == 0);
            step();
        end
        clear_req = 1'b0; sat_alarm = 1'b0;

        // Reset in the middle of a data block at blk_cnt 7.
        for (int i = 0; i < 200 && m_in_clear; i++) step();
        in_valid = 1'b1; in_data = 16'h1234;
        wait_model(7, 1'b0, "wait_blk7");
        arst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        model_reset();
        k_h = 0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        compare_all();

        // After release: clear sequence first, then streamed data.
        for (int i = 0; i < 80; i++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
